// File: rtl/l2_data_ram_ctrl.sv
// L2 data RAM controller: clears the single-port SRAM after reset, then serves
// byte-strobed writes and reads with a 2-entry in-order read-response FIFO.
module l2_data_ram_ctrl #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 256,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [SW-1:0] req_strob_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          init_done_o,
  output logic          ram_cs_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [SW-1:0] ram_strob_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int unsigned OCC_W = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   init_cnt;
  logic [DW-1:0]   fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      cnt;
  logic            rd_pend;

  logic             run;
  logic             accept;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;

  // Occupancy counts the read already in the SRAM pipe so the FIFO can never overflow.
  assign run         = (state == RUN) & ~rst_i;
  assign push        = rd_pend;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign occ         = OCC_W'(cnt) + OCC_W'(rd_pend) - OCC_W'(pop);
  assign req_ready_o = run & (occ < OCC_W'(2));
  assign accept      = req_valid_i & req_ready_o;
  assign init_done_o = run;
  assign rsp_valid_o = ~rst_i & (cnt != 2'd0);
  assign rsp_rdata_o = fifo_mem[rd_ptr];

  // SRAM port mux: clear sweep during INIT, pass-through of accepted requests in RUN.
  always_comb begin
    ram_cs_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_strob_o = '0;
    if (!rst_i) begin
      if (state == INIT) begin
        ram_cs_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = init_cnt;
        ram_strob_o = '1;
      end else begin
        ram_cs_o   = accept;
        ram_we_o   = req_we_i;
        ram_addr_o = req_addr_i;
        if (req_we_i) begin
          ram_wdata_o = req_wdata_i;
          ram_strob_o = req_strob_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
      cnt      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rd_pend  <= 1'b0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + AW'(1);
        if (init_cnt == {AW{1'b1}}) begin
          state <= RUN;
        end
      end
      rd_pend <= accept & ~req_we_i;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_rdata_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
      assert (!(push && !pop && (cnt == 2'd2)));
    end
  end

endmodule

// File: tb/tb_l2_data_ram_ctrl.sv
// Directed bench for l2_data_ram_ctrl with a behavioural single-port SRAM model.
module tb_l2_data_ram_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 256;
  localparam int unsigned SW    = 32;
  localparam int unsigned DEPTH = 512;

  localparam logic [DW-1:0] PAT      = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [DW-1:0] PAT_LOW8 = {192'b0, 64'h0123_4567_89AB_CDEF};
  localparam logic [DW-1:0] ALL_A5   = {32{8'hA5}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strob = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [SW-1:0] ram_strob;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  l2_data_ram_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_strob_i (req_strob),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .init_done_o (init_done),
    .ram_cs_o    (ram_cs),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_strob_o (ram_strob),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked write, registered read one cycle after cs.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int k = 0; k < int'(SW); k++) begin
          if (ram_strob[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  function automatic logic [DW-1:0] data_of(input int k);
    return {8{32'h5A00_0000 | 32'(k)}};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_strob = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, AW'(7), '0, '0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, init_done, ram_cs} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got rdy/val/done/cs=%b expected 0000",
               {req_ready, rsp_valid, init_done, ram_cs});
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
  endtask

  task automatic test_init();
    int nz;
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      checks++;
      if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_wdata !== '0 ||
          ram_strob !== '1 || init_done !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep cycle=%0d got cs=%b we=%b addr=%0d strob=%h done=%b rdy=%b expected addr=%0d",
                 i, ram_cs, ram_we, ram_addr, ram_strob, init_done, req_ready, i);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_done cycle=512 got done=%b rdy=%b expected 1 1", init_done, req_ready);
    end
    nz = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL init_clear got %0d nonzero lines expected 0", nz);
    end
    next_cycle();
    drive(1'b1, 1'b0, AW'(5), '0, '0);
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'(5)) begin
      failures++;
      $display("FAIL read5_issue got cs=%b we=%b addr=%0d expected 1 0 5", ram_cs, ram_we, ram_addr);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read5_early got rsp_valid=%b expected 0", rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== '0) begin
      failures++;
      $display("FAIL read5_data got valid=%b rdata=%h expected 1 0", rsp_valid, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_strobe_write();
    drive(1'b1, 1'b1, AW'(9'h1A0), PAT, 32'h0000_00FF);
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_strob !== 32'h0000_00FF || ram_wdata !== PAT) begin
      failures++;
      $display("FAIL strb_write_issue got cs=%b we=%b strob=%h expected 1 1 000000ff", ram_cs, ram_we, ram_strob);
    end
    next_cycle();
    drive(1'b1, 1'b0, AW'(9'h1A0), PAT, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_wdata !== '0 || ram_strob !== '0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL strb_read_issue got cs=%b wdata_nz=%b strob=%h valid=%b expected 1 0 0 0",
               ram_cs, |ram_wdata, ram_strob, rsp_valid);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_no_rsp got rsp_valid=%b expected 0", rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_LOW8) begin
      failures++;
      $display("FAIL strb_readback got valid=%b rdata=%h expected 1 %h", rsp_valid, rsp_rdata, PAT_LOW8);
    end
    next_cycle();
  endtask

  task automatic test_zero_strobe();
    drive(1'b1, 1'b1, AW'(9'h1A0), '1, '0);
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_strob !== '0) begin
      failures++;
      $display("FAIL zero_strb_issue got cs=%b we=%b strob=%h expected 1 1 0", ram_cs, ram_we, ram_strob);
    end
    next_cycle();
    drive(1'b1, 1'b0, AW'(9'h1A0), '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_LOW8) begin
      failures++;
      $display("FAIL zero_strb_readback got valid=%b rdata=%h expected 1 %h", rsp_valid, rsp_rdata, PAT_LOW8);
    end
    next_cycle();
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b1, AW'(3), ALL_A5, '1);
    next_cycle();
    drive(1'b1, 1'b0, AW'(3), '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL raw_early got rsp_valid=%b expected 0", rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ALL_A5) begin
      failures++;
      $display("FAIL raw_data got valid=%b rdata=%h expected 1 %h", rsp_valid, rsp_rdata, ALL_A5);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, AW'(16 + k), data_of(k), '1);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_write_ready k=%0d got %b expected 1", k, req_ready);
      end
      next_cycle();
    end
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1'b1, 1'b0, AW'(16 + c), '0, '0);
      else        drive(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (c < 16) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_read_ready c=%0d got %b expected 1", c, req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== data_of(c - 2)) begin
          failures++;
          $display("FAIL b2b_rsp c=%0d got valid=%b rdata=%h expected 1 %h",
                   c, rsp_valid, rsp_rdata, data_of(c - 2));
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got rsp_valid=%b expected 0", rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [10:0] rdy_tab;
    logic [10:0] val_tab;
    int          idx_tab [11];
    logic        exp_cs;
    rdy_tab = 11'b11111000011;
    val_tab = 11'b01111111100;
    idx_tab = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    for (int c = 0; c < 11; c++) begin
      rsp_ready = (c >= 6);
      if (c == 0)      drive(1'b1, 1'b0, AW'(16), '0, '0);
      else if (c == 1) drive(1'b1, 1'b0, AW'(17), '0, '0);
      else if (c <= 6) drive(1'b1, 1'b0, AW'(18), '0, '0);
      else if (c == 7) drive(1'b1, 1'b0, AW'(19), '0, '0);
      else             drive(1'b0, 1'b0, '0, '0, '0);
      exp_cs = req_valid & rdy_tab[c];
      @(negedge clk);
      checks++;
      if (req_ready !== rdy_tab[c] || ram_cs !== exp_cs || rsp_valid !== val_tab[c] ||
          (val_tab[c] && rsp_rdata !== data_of(idx_tab[c]))) begin
        failures++;
        $display("FAIL backpressure c=%0d got rdy=%b cs=%b valid=%b rdata=%h expected %b %b %b %h",
                 c, req_ready, ram_cs, rsp_valid, rsp_rdata, rdy_tab[c], exp_cs, val_tab[c],
                 data_of(idx_tab[c]));
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, AW'(16), '0, '0);
    next_cycle();
    drive(1'b1, 1'b0, AW'(17), '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== data_of(0)) begin
      failures++;
      $display("FAIL midrst_full got valid=%b rdy=%b rdata=%h expected 1 0 %h",
               rsp_valid, req_ready, rsp_rdata, data_of(0));
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, init_done, ram_cs} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_during got rdy/val/done/cs=%b expected 0000",
               {req_ready, rsp_valid, init_done, ram_cs});
    end
    next_cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      if (i < 2 || i == int'(DEPTH) - 1) begin
        checks++;
        if (rsp_valid !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== AW'(i) || init_done !== 1'b0) begin
          failures++;
          $display("FAIL midrst_init i=%0d got valid=%b cs=%b addr=%0d done=%b expected 0 1 %0d 0",
                   i, rsp_valid, ram_cs, ram_addr, init_done, i);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL midrst_done got %b expected 1", init_done);
    end
    next_cycle();
    drive(1'b1, 1'b0, AW'(3), '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== '0) begin
      failures++;
      $display("FAIL midrst_recleared got valid=%b rdata=%h expected 1 0", rsp_valid, rsp_rdata);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {8{32'hDEAD_BEEF}};
    test_reset();
    test_init();
    test_strobe_write();
    test_zero_strobe();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_data_ram_ctrl.md
L2_DATA_RAM_CTRL -- requirements
Module: l2_data_ram_ctrl

Interface
REQ-001 SHALL have parameter AW, 9, SRAM address width (depth 2**AW = 512).
REQ-002 SHALL have parameter DW, 256, data width.
REQ-003 SHALL have parameter SW, DW/8 = 32, byte-strobe width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  1  request valid.
REQ-007 SHALL have port req_ready_o  output  1  request accepted when valid&ready.
REQ-008 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr_i  input  AW  line address.
REQ-010 SHALL have port req_wdata_i  input  DW  write data.
REQ-011 SHALL have port req_strob_i  input  SW  byte enables; bit k covers wdata[8k+7:8k].
REQ-012 SHALL have port rsp_valid_o  output  1  read data valid.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer accepts read data.
REQ-014 SHALL have port rsp_rdata_o  output  DW  read data.
REQ-015 SHALL have port init_done_o  output  1  RAM clear complete.
REQ-016 SHALL have ports ram_cs_o, ram_we_o (1), ram_addr_o (AW), ram_wdata_o (DW), ram_strob_o (SW)  output, and ram_rdata_i (DW)  input; single-port SRAM, read data valid one cycle after cs with we=0.

Function
REQ-017 SHALL implement FSM with states INIT and RUN; reset enters INIT.
REQ-018 SHALL, in INIT, drive ram_cs_o=1, ram_we_o=1, ram_strob_o=all ones, ram_wdata_o=0, ram_addr_o=init counter, every cycle.
REQ-019 SHALL increment the AW-bit init counter each INIT cycle from 0; after writing address 2**AW-1 go to RUN (INIT lasts exactly 512 cycles).
REQ-020 SHALL hold req_ready_o=0 and init_done_o=0 in INIT; init_done_o=1 in RUN.
REQ-021 SHALL, in RUN, drive ram_cs_o = req_valid_i & req_ready_o combinationally, with ram_we_o=req_we_i, ram_addr_o=req_addr_i, ram_wdata_o/ram_strob_o = request values on writes, zero on reads.
REQ-022 SHALL keep a 2-entry in-order response FIFO and a rd_pend flag set the cycle after an accepted read.
REQ-023 SHALL push ram_rdata_i into the FIFO in the cycle rd_pend=1.
REQ-024 SHALL compute req_ready_o = RUN & (cnt + rd_pend - (rsp_valid_o & rsp_ready_i) < 2), independent of req_we_i.
REQ-025 SHALL give read latency: accepted at cycle N -> rsp_valid_o=1 with data at N+2.
REQ-026 SHALL sustain one request per cycle when rsp_ready_i=1 continuously.
REQ-027 SHALL present rsp_valid_o = (cnt != 0), rsp_rdata_o = FIFO head; hold head stable while valid & !ready.
REQ-028 SHALL allow simultaneous push and pop; count unchanged, order preserved.
REQ-029 SHALL never overflow the FIFO; a push with cnt=2 and no pop is a design error (assertion).
REQ-030 SHALL produce no response for writes; a write at N followed by a read of the same address at N+1 returns the written bytes.
REQ-031 SHALL issue strobe-all-zero writes to the SRAM unchanged (no bytes modified).

Reset
REQ-032 SHALL, on rst_i=1 at any edge, clear FIFO count, pointers, rd_pend, init counter; enter INIT; outputs req_ready_o=0, rsp_valid_o=0, init_done_o=0, ram_cs_o=0 during the reset cycle.
REQ-033 SHALL discard in-flight reads on reset mid-operation; INIT restarts at address 0.

Verification
REQ-034 SHALL test: release reset -> exactly 512 zero writes addr 0..511, init_done_o=1 at cycle 512; then read addr 5 -> rdata 0.
REQ-035 SHALL test: write addr 0x1A0 data pattern, strobe 0x0000_00FF; read back -> bytes 0-7 = pattern, bytes 8-31 = 0, at N+2.
REQ-036 SHALL test: 16 back-to-back reads, rsp_ready_i=1 -> req_ready_o stays 1, 16 in-order responses, one per cycle.
REQ-037 SHALL test: rsp_ready_i=0, issue reads -> 2 accepted, req_ready_o=0, rsp_rdata_o stable; raise ready -> drain in order, accept resumes.
REQ-038 SHALL test: write addr 3 = 0xA5.. at N, read addr 3 at N+1 -> 0xA5.. at N+3.
REQ-039 SHALL test: assert rst_i with 2 responses buffered -> rsp_valid_o=0 next cycle, INIT restarts at address 0.
